// File: rtl/pipe_pkg.sv
// pipe_pkg: shared MDU state encoding, default latencies and the $zero register constant
package pipe_pkg;
  typedef enum logic {IDLE, MD_RUN} md_state_e;
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam logic [4:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: loadable down-counter tracking mult/div busy cycles after launch from E
module md_busy_counter
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic is_div,
  output logic busy
);
  md_state_e state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  // state and counter registers; reset clears a running count at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // a launch always (re)loads; otherwise count down and leave MD_RUN on the last busy cycle
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (start) begin
      state_nx = MD_RUN;
      cnt_nx = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (state == MD_RUN) begin
      cnt_nx = cnt - CNT_W'(1);
      state_nx = (cnt == CNT_W'(1)) ? IDLE : MD_RUN;
    end
  end
  assign busy = cnt != '0;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline; MDU tracking built only with PIPE_HAZARD_MDU_EN
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        use_rs_D,
  input  logic        use_rt_D,
  input  logic        is_branch_D,
  input  logic        md_use_D,
  input  logic [4:0]  wa_E,
  input  logic [4:0]  wa_M,
  input  logic        RegWrite_E,
  input  logic        MemToReg_E,
  input  logic        RegWrite_M,
  input  logic        MemToReg_M,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        exc_M,
  input  logic        eret_M,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_D,
  output logic        flush_E,
  output logic        flush_M,
  output logic        md_busy,
  output logic [15:0] stall_cnt
);
  logic match_E, match_M, lu, br, md, fl, stall;
  assign fl = exc_M | eret_M;
`ifdef PIPE_HAZARD_MDU_EN
  md_busy_counter #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .start(md_start_E & ~fl),
    .is_div(md_is_div_E),
    .busy(md_busy)
  );
  assign md = md_use_D & (md_busy | md_start_E);
`else
  logic unused_md;
  assign unused_md = ^{md_use_D, md_start_E, md_is_div_E, (MULT_LAT + DIV_LAT + CNT_W) == 0};
  assign md_busy = 1'b0;
  assign md = 1'b0;
`endif
  // hazard terms and prioritised stall/flush outputs; a flush squashes every stall
  always_comb begin
    match_E = RegWrite_E && wa_E != ZERO_REG && ((use_rs_D && rs_D == wa_E) || (use_rt_D && rt_D == wa_E));
    match_M = RegWrite_M && wa_M != ZERO_REG && ((use_rs_D && rs_D == wa_M) || (use_rt_D && rt_D == wa_M));
    lu = match_E & MemToReg_E;
    br = is_branch_D & (match_E | (match_M & MemToReg_M));
    stall = ~fl & (lu | br | md);
    stall_F = stall;
    stall_D = stall;
    flush_D = fl;
    flush_E = fl | stall;
    flush_M = fl;
  end
  // saturating count of cycles with D held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (stall_D && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors plus a per-cycle reference model of the hazard rules
module tb_pipe_hazard_ctrl;
  logic clk = 0, rst_n = 0;
  logic [4:0] rs_D, rt_D, wa_E, wa_M;
  logic use_rs_D, use_rt_D, is_branch_D, md_use_D;
  logic RegWrite_E, MemToReg_E, RegWrite_M, MemToReg_M;
  logic md_start_E, md_is_div_E, exc_M, eret_M;
  logic stall_F, stall_D, flush_D, flush_E, flush_M, md_busy;
  logic [15:0] stall_cnt;
  int n_chk = 0, n_fail = 0;
`ifdef PIPE_HAZARD_MDU_EN
  localparam bit MDU = 1;
`else
  localparam bit MDU = 0;
`endif
  int mdl_left = 0;
  int mdl_cnt = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .is_branch_D(is_branch_D), .md_use_D(md_use_D), .wa_E(wa_E), .wa_M(wa_M),
    .RegWrite_E(RegWrite_E), .MemToReg_E(MemToReg_E), .RegWrite_M(RegWrite_M), .MemToReg_M(MemToReg_M),
    .md_start_E(md_start_E), .md_is_div_E(md_is_div_E), .exc_M(exc_M), .eret_M(eret_M),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit reads(input logic [4:0] r);
    return r != 5'd0 && ((use_rs_D && rs_D == r) || (use_rt_D && rt_D == r));
  endfunction

  function automatic bit mdl_flush();
    return exc_M || eret_M;
  endfunction

  function automatic bit mdl_stall();
    bit load_use, branch, mdu;
    load_use = RegWrite_E && MemToReg_E && reads(wa_E);
    branch = is_branch_D && ((RegWrite_E && reads(wa_E)) || (RegWrite_M && MemToReg_M && reads(wa_M)));
    mdu = MDU && md_use_D && (mdl_left > 0 || md_start_E);
    return !mdl_flush() && (load_use || branch || mdu);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_left = 0;
      mdl_cnt = 0;
    end else begin
      if (mdl_stall() && mdl_cnt < 65535) mdl_cnt = mdl_cnt + 1;
      if (MDU && md_start_E && !mdl_flush()) mdl_left = md_is_div_E ? 10 : 5;
      else if (mdl_left > 0) mdl_left = mdl_left - 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_stall_F", stall_F, mdl_stall());
      chk("m_stall_D", stall_D, mdl_stall());
      chk("m_flush_D", flush_D, mdl_flush());
      chk("m_flush_E", flush_E, mdl_flush() || mdl_stall());
      chk("m_flush_M", flush_M, mdl_flush());
      chk("m_md_busy", md_busy, mdl_left > 0);
      chk("m_stall_cnt", stall_cnt, mdl_cnt);
    end
  end

  task automatic idle();
    {rs_D, rt_D, wa_E, wa_M} = '0;
    {use_rs_D, use_rt_D, is_branch_D, md_use_D} = '0;
    {RegWrite_E, MemToReg_E, RegWrite_M, MemToReg_M} = '0;
    {md_start_E, md_is_div_E, exc_M, eret_M} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cyc;
    idle();
    repeat (2) tick();
    @(negedge clk);
    chk("rst_stall_F", stall_F, 0);
    chk("rst_stall_D", stall_D, 0);
    chk("rst_flush", {flush_D, flush_E, flush_M}, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    tick();
    rst_n = 1;
    // lw $8 in E, add reading $8 in D
    RegWrite_E = 1; MemToReg_E = 1; wa_E = 8; use_rs_D = 1; rs_D = 8;
    @(negedge clk);
    chk("lu_stall", {stall_F, stall_D, flush_E}, 3'b111);
    tick();
    idle();
    @(negedge clk);
    chk("lu_release", stall_D, 0);
    chk("lu_cnt", stall_cnt, 1);
    // beq reading $9 with ALU producer in E: one stall cycle
    tick();
    is_branch_D = 1; use_rs_D = 1; rs_D = 9; RegWrite_E = 1; wa_E = 9;
    @(negedge clk);
    chk("br_alu_1", stall_D, 1);
    tick();
    RegWrite_E = 0; wa_E = 0; RegWrite_M = 1; wa_M = 9;
    @(negedge clk);
    chk("br_alu_2", stall_D, 0);
    // beq reading $9 with load producer in E: two stall cycles
    tick();
    RegWrite_M = 0; wa_M = 0; RegWrite_E = 1; MemToReg_E = 1; wa_E = 9;
    @(negedge clk);
    chk("br_ld_1", stall_D, 1);
    tick();
    RegWrite_E = 0; MemToReg_E = 0; wa_E = 0; RegWrite_M = 1; MemToReg_M = 1; wa_M = 9;
    @(negedge clk);
    chk("br_ld_2", stall_D, 1);
    tick();
    RegWrite_M = 0; MemToReg_M = 0; wa_M = 0;
    @(negedge clk);
    chk("br_ld_3", stall_D, 0);
    chk("br_cnt", stall_cnt, 4);
    // load-use through rt
    tick();
    idle();
    use_rt_D = 1; rt_D = 12; rs_D = 12; RegWrite_E = 1; MemToReg_E = 1; wa_E = 12;
    @(negedge clk);
    chk("lu_rt", stall_F, 1);
    // writes to $zero never stall
    tick();
    idle();
    RegWrite_E = 1; MemToReg_E = 1; wa_E = 0; use_rs_D = 1; rs_D = 0; is_branch_D = 1;
    @(negedge clk);
    chk("zero_reg", {stall_F, stall_D, flush_E}, 0);
    // exception over a load-use condition
    tick();
    idle();
    RegWrite_E = 1; MemToReg_E = 1; wa_E = 8; use_rs_D = 1; rs_D = 8; exc_M = 1;
    @(negedge clk);
    chk("exc_flush", {flush_D, flush_E, flush_M}, 3'b111);
    chk("exc_stall", {stall_F, stall_D}, 0);
    // eret coinciding with a div launch: the launch is squashed
    tick();
    idle();
    eret_M = 1; md_start_E = 1; md_is_div_E = 1;
    @(negedge clk);
    chk("eret_flush", {flush_D, flush_E, flush_M, stall_F}, 4'b1110);
    tick();
    idle();
    @(negedge clk);
    chk("fl_no_load", md_busy, 0);
    tick();
`ifdef PIPE_HAZARD_MDU_EN
    // div in E with mflo in D
    md_start_E = 1; md_is_div_E = 1; md_use_D = 1;
    @(negedge clk);
    chk("div_launch_stall", stall_D, 1);
    tick();
    md_start_E = 0; md_is_div_E = 0;
    busy_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!md_busy) break;
      busy_cyc++;
      tick();
    end
    chk("div_busy_cycles", busy_cyc, 10);
    chk("div_release", stall_D, 0);
    // mult, then reset with three cycles remaining
    tick();
    idle();
    md_start_E = 1;
    tick();
    md_start_E = 0;
    tick();
    tick();
    @(negedge clk);
    chk("mult_busy", md_busy, 1);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_busy", md_busy, 0);
    chk("rst_mid_cnt", stall_cnt, 0);
    tick();
    rst_n = 1;
    md_use_D = 1;
    @(negedge clk);
    chk("rst_mid_idle", {md_busy, stall_D}, 0);
`else
    md_start_E = 1; md_is_div_E = 1; md_use_D = 1;
    @(negedge clk);
    chk("nomdu_stall", stall_D, 0);
    tick();
    md_start_E = 0;
    busy_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (md_busy) busy_cyc++;
      tick();
    end
    chk("nomdu_busy", busy_cyc, 0);
`endif
    tick();
    idle();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
